alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; all requirements below use WIDTH=16.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 num1  input  [0:15]  first operand, unsigned binary; bit 0 is the MSB.
REQ-006 num2  input  [0:15]  second operand, unsigned binary; bit 0 is the MSB.
REQ-007 op  input  [0:1]  operation select: 0 add, 1 subtract, 2 multiply, 3 divide.
REQ-008 res  output  [0:15]  registered result, unsigned; bit 0 is the MSB.
REQ-009 isValid  output  1  registered flag; 1 means res holds the exact arithmetic result.

Function
REQ-010 The block SHALL sample num1, num2 and op on every rising edge and present res/isValid on the following edge: latency 1 cycle, throughput 1 operation per cycle, no handshake.
REQ-011 op=0 (add): res = (num1+num2) mod 2^16; isValid=0 if a carry out of bit 0 occurs, else 1.
REQ-012 op=1 (subtract): res = (num1-num2) mod 2^16; isValid=0 if num2>num1 (borrow), else 1; num1=num2 gives res=0, isValid=1.
REQ-013 op=2 (multiply): res = low 16 bits of the 32-bit product; isValid=0 if any of the upper 16 product bits is nonzero.
REQ-014 op=3 (divide): res = floor(num1/num2), remainder discarded; isValid=1 when num2 != 0.
REQ-015 Divide by zero: res=16'hFFFF, isValid=0.
REQ-016 For every invalid result other than divide by zero, res SHALL still carry the wrapped/truncated value defined above.
REQ-017 Operands of 0 SHALL be legal for all ops; 0+0, 0-0, 0*x and 0/x (x != 0) give res=0, isValid=1.
REQ-018 Changes on the inputs between clock edges SHALL have no effect on the outputs until the next rising edge.

Reset
REQ-019 While rst=1 at a rising edge: res <= 0, isValid <= 0.
REQ-020 rst SHALL override any operation in flight; on the first edge with rst=0, the block computes from the inputs present at that edge.

Configuration
REQ-021 Macro ALU_DIV_EN: when defined, op=3 SHALL behave per REQ-014/REQ-015.
REQ-022 When ALU_DIV_EN is undefined, the divider SHALL be absent and op=3 SHALL give res=0, isValid=0.

Structure
REQ-023 A shared package alu_pkg SHALL hold the WIDTH default and the op encodings OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3.
REQ-024 The division SHALL be a sub-module alu_div16: a combinational 16-stage restoring divider with outputs quotient and div-by-zero flag, instantiated only under ALU_DIV_EN.
REQ-025 The add, subtract and multiply datapaths and the output registers SHALL reside in alu.

Verification
REQ-026 num1=5, num2=1, op=0 -> after one edge: res=6, isValid=1.
REQ-027 num1=16'hFFFF, num2=1, op=0 -> res=0, isValid=0; then num1=3, num2=5, op=1 -> res=16'hFFFE, isValid=0.
REQ-028 num1=300, num2=300, op=2 -> res=16'h5F90 (90000 mod 65536), isValid=0; num1=255, num2=257, op=2 -> res=65535, isValid=1.
REQ-029 num1=100, num2=7, op=3 -> res=14, isValid=1; num1=100, num2=0, op=3 -> res=16'hFFFF, isValid=0 (with ALU_DIV_EN defined).
REQ-030 Back-to-back ops on consecutive cycles (add, sub, mul, div) -> each result appears exactly one cycle after its operands.
REQ-031 Assert rst mid-stream with valid ops applied -> res=0, isValid=0 at the next edge; release rst -> correct result one edge later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width and operation encodings.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

endpackage

// File: rtl/alu_div16.sv
// Combinational restoring divider, one compare/subtract stage per quotient bit.
// A zero divisor yields an all-ones quotient and raises o_div_by_zero.
module alu_div16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_num,
    input  logic [WIDTH-1:0] i_den,
    output logic [WIDTH-1:0] o_quotient,
    output logic             o_div_by_zero
);

    logic [WIDTH:0]   w_rem;
    logic [WIDTH-1:0] w_quot;

    // Partial remainder is one bit wider so the shifted value never overflows.
    always_comb begin
        w_rem  = '0;
        w_quot = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_rem = {w_rem[WIDTH-1:0], i_num[i]};
            if (w_rem >= {1'b0, i_den}) begin
                w_rem     = w_rem - {1'b0, i_den};
                w_quot[i] = 1'b1;
            end
        end
    end

    assign o_quotient    = w_quot;
    assign o_div_by_zero = (i_den == '0);

endmodule

// File: rtl/alu.sv
// Single-cycle-latency unsigned ALU (add/sub/mul/div) with registered result and validity flag.
// Divide support is built only when ALU_DIV_EN is defined; otherwise op=3 returns res=0, isValid=0.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:WIDTH-1] num1,
    input  logic [0:WIDTH-1] num2,
    input  logic [0:1]       op,
    output logic [0:WIDTH-1] res,
    output logic             isValid
);

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res_nxt;
    logic               w_valid_nxt;
    logic [WIDTH-1:0]   r_res;
    logic               r_valid;

    // Port bit 0 is the MSB; these copies give conventional [MSB:0] arithmetic.
    assign w_a = num1;
    assign w_b = num2;

    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};
    assign w_prod = {{WIDTH{1'b0}}, w_a} * {{WIDTH{1'b0}}, w_b};

`ifdef ALU_DIV_EN
    logic [WIDTH-1:0] w_quot;
    logic             w_dbz;

    alu_div16 #(
        .WIDTH(WIDTH)
    ) u_div (
        .i_num        (w_a),
        .i_den        (w_b),
        .o_quotient   (w_quot),
        .o_div_by_zero(w_dbz)
    );
`endif

    always_comb begin
        w_res_nxt   = '0;
        w_valid_nxt = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                w_res_nxt   = w_sum[WIDTH-1:0];
                w_valid_nxt = ~w_sum[WIDTH];
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow.
                w_res_nxt   = w_diff[WIDTH-1:0];
                w_valid_nxt = ~w_diff[WIDTH];
            end
            OP_MUL: begin
                w_res_nxt   = w_prod[WIDTH-1:0];
                w_valid_nxt = (w_prod[2*WIDTH-1:WIDTH] == '0);
            end
            OP_DIV: begin
`ifdef ALU_DIV_EN
                w_res_nxt   = w_quot;
                w_valid_nxt = ~w_dbz;
`else
                w_res_nxt   = '0;
                w_valid_nxt = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_res   <= w_res_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign res     = r_res;
    assign isValid = r_valid;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; divide expectations follow ALU_DIV_EN.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [0:15] num1;
    logic [0:15] num2;
    logic [0:1]  op;
    logic [0:15] res;
    logic        isValid;

    int n_tests;
    int n_fail;

    alu #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .num1   (num1),
        .num2   (num2),
        .op     (op),
        .res    (res),
        .isValid(isValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive operands at the falling edge, then check one rising edge later.
    task automatic apply(input string tag, input logic r, input logic [15:0] a,
                         input logic [15:0] b, input logic [1:0] o,
                         input logic [15:0] exp_res, input logic exp_v);
        @(negedge clk);
        rst  = r;
        num1 = a;
        num2 = b;
        op   = o;
        @(posedge clk);
        #1;
        check({tag, ".res"}, 32'(res), 32'(exp_res));
        check({tag, ".vld"}, 32'(isValid), 32'(exp_v));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst  = 1'b1;
        num1 = 16'd5;
        num2 = 16'd1;
        op   = 2'd0;

        // Reset with a valid add on the inputs.
        apply("reset0", 1'b1, 16'd5, 16'd1, 2'd0, 16'h0000, 1'b0);
        apply("reset1", 1'b1, 16'd5, 16'd1, 2'd0, 16'h0000, 1'b0);

        // First edge after release computes from inputs present at that edge.
        apply("add5p1", 1'b0, 16'd5, 16'd1, 2'd0, 16'd6, 1'b1);
        apply("addcarry", 1'b0, 16'hFFFF, 16'd1, 2'd0, 16'h0000, 1'b0);
        apply("subborrow", 1'b0, 16'd3, 16'd5, 2'd1, 16'hFFFE, 1'b0);
        apply("mul300", 1'b0, 16'd300, 16'd300, 2'd2, 16'h5F90, 1'b0);
        apply("mul255x257", 1'b0, 16'd255, 16'd257, 2'd2, 16'hFFFF, 1'b1);
        apply("addmax0", 1'b0, 16'hFFFF, 16'h0000, 2'd0, 16'hFFFF, 1'b1);
        apply("add00", 1'b0, 16'd0, 16'd0, 2'd0, 16'd0, 1'b1);
        apply("subeq", 1'b0, 16'd7, 16'd7, 2'd1, 16'd0, 1'b1);
        apply("sub00", 1'b0, 16'd0, 16'd0, 2'd1, 16'd0, 1'b1);
        apply("sub0m1", 1'b0, 16'd0, 16'd1, 2'd1, 16'hFFFF, 1'b0);
        apply("sub1000m1", 1'b0, 16'd1000, 16'd1, 2'd1, 16'd999, 1'b1);
        apply("mul0x", 1'b0, 16'd0, 16'h1234, 2'd2, 16'd0, 1'b1);
        apply("mul8000x2", 1'b0, 16'h8000, 16'd2, 2'd2, 16'h0000, 1'b0);
        apply("mul12x11", 1'b0, 16'd12, 16'd11, 2'd2, 16'd132, 1'b1);

`ifdef ALU_DIV_EN
        apply("div100by7", 1'b0, 16'd100, 16'd7, 2'd3, 16'd14, 1'b1);
        apply("div100by0", 1'b0, 16'd100, 16'd0, 2'd3, 16'hFFFF, 1'b0);
        apply("div0by5", 1'b0, 16'd0, 16'd5, 2'd3, 16'd0, 1'b1);
        apply("divmaxby1", 1'b0, 16'hFFFF, 16'd1, 2'd3, 16'hFFFF, 1'b1);
        apply("divmaxby3", 1'b0, 16'hFFFF, 16'd3, 2'd3, 16'd21845, 1'b1);
        apply("div3by5", 1'b0, 16'd3, 16'd5, 2'd3, 16'd0, 1'b1);
`else
        apply("div100by7", 1'b0, 16'd100, 16'd7, 2'd3, 16'd0, 1'b0);
        apply("div100by0", 1'b0, 16'd100, 16'd0, 2'd3, 16'd0, 1'b0);
`endif

        // Back-to-back add, sub, mul, div on consecutive cycles.
        apply("b2b_add", 1'b0, 16'd1000, 16'd24, 2'd0, 16'd1024, 1'b1);
        apply("b2b_sub", 1'b0, 16'd1000, 16'd24, 2'd1, 16'd976, 1'b1);
        apply("b2b_mul", 1'b0, 16'd1000, 16'd24, 2'd2, 16'd24000, 1'b1);
`ifdef ALU_DIV_EN
        apply("b2b_div", 1'b0, 16'd1000, 16'd24, 2'd3, 16'd41, 1'b1);
`else
        apply("b2b_div", 1'b0, 16'd1000, 16'd24, 2'd3, 16'd0, 1'b0);
`endif

        // Input changes between edges must not reach the outputs.
        apply("hold_pre", 1'b0, 16'd20, 16'd22, 2'd0, 16'd42, 1'b1);
        #1;
        num1 = 16'hFFFF;
        num2 = 16'hFFFF;
        op   = 2'd2;
        #1;
        check("hold.res", 32'(res), 32'd42);
        check("hold.vld", 32'(isValid), 32'd1);

        // Reset mid-stream overrides a valid op, release recomputes.
        apply("mid_pre", 1'b0, 16'd9, 16'd9, 2'd2, 16'd81, 1'b1);
        apply("mid_rst", 1'b1, 16'd9, 16'd9, 2'd2, 16'd0, 1'b0);
        apply("mid_rel", 1'b0, 16'd9, 16'd9, 2'd2, 16'd81, 1'b1);
        apply("mid_next", 1'b0, 16'd9, 16'd10, 2'd1, 16'hFFFF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
